rmgmt_mem_servicer: RTL
=======================

// Module: rmgmt_mem_servicer
// PURPOSE
//  Pipeline-side responder for RISC-MGMT memory requests. Arbitrates extension loads/stores
//  against the core execute-stage data port onto the single data bus. Returns load data,
//  busy and misalignment fault to the extension. Sits between execute stage, RISC-MGMT, dcache bus.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width (word accesses only, byte_en fixed 4'hF for RM accesses)
// PORTS
//  CLK            in   1       clock, rising edge
//  nRST           in   1       async active-low reset
//  rm_req_mem     in   1       RISC-MGMT requests memory this cycle
//  rm_mem_ren     in   1       RM read
//  rm_mem_wen     in   1       RM write
//  rm_mem_addr    in   ADDR_W  RM address
//  rm_mem_store   in   DATA_W  RM store data
//  rm_flush       in   1       squash pending RM request (pipeline flush)
//  rm_mem_load    out  DATA_W  RM load data, valid while rm_mem_done=1
//  rm_mem_busy    out  1       RM access not yet complete (stall execute)
//  rm_mem_done    out  1       one-cycle completion pulse
//  rm_mem_fault   out  1       one-cycle misaligned/illegal pulse (with rm_mem_done)
//  core_ren/wen   in   1/1     core data request
//  core_addr      in   ADDR_W  core address
//  core_wdata     in   DATA_W  core store data
//  core_byte_en   in   4       core byte enables
//  core_rdata     out  DATA_W  bus_rdata passthrough while core granted
//  core_busy      out  1       core access not complete
//  bus_ren/wen    out  1/1     data bus request
//  bus_addr       out  ADDR_W  data bus address
//  bus_wdata      out  DATA_W  data bus store data
//  bus_byte_en    out  4       data bus byte enables
//  bus_rdata      in   DATA_W  data bus load data, valid when bus_busy=0
//  bus_busy       in   1       bus transfer in progress
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except core_busy/rm_mem_busy follow their request inputs.
//  FSM IDLE, CORE_XFER, RM_XFER, RM_DONE (codes in package).
//  IDLE: core_ren|core_wen -> CORE_XFER (core wins ties); else rm_req_mem&(ren|wen)&!rm_flush:
//   addr[1:0]!=0 or ren&wen -> RM_DONE with fault, no bus access; else latch addr/store/op -> RM_XFER.
//  CORE_XFER: bus driven combinationally from core inputs; core_busy=bus_busy;
//   bus_busy=0 -> IDLE. rm_mem_busy=rm_req_mem throughout.
//  RM_XFER: bus driven from latched regs (stable regardless of RM inputs); core_busy=core request;
//   bus_busy=0 -> capture bus_rdata (reads) into rm_mem_load, -> RM_DONE.
//  RM_DONE: rm_mem_busy=0, rm_mem_done=1, fault as latched; unconditional -> IDLE next cycle.
//   Back-to-back RM requests re-arbitrate in IDLE (min 3 cycles/RM access on zero-wait bus).
//  rm_mem_busy = rm_req_mem & !(state==RM_DONE); in IDLE/XFER with a request it is 1.
//  rm_flush: in IDLE drops request. In RM_XFER bus transfer completes (no abort), result
//   discarded: -> IDLE, no done/fault pulse. Flush latched if deasserted before completion.
//  Core request arriving in RM_XFER waits; no preemption.
//  rm_mem_load holds last captured value outside RM_DONE; write completion leaves it unchanged.
//  Async reset mid-transfer: FSM to IDLE immediately, bus_ren/wen drop; no completion pulses.
// STRUCTURE
//  Package rmgmt_mem_pkg: rmgmt_mem_state_t enum, RM_BYTE_EN=4'hF, word_t reuse from rv32i_types_pkg.
//  Single module; no sub-module (FSM + latch regs + output muxes).
// TESTING
//  RM read addr 0x100, bus 2 wait -> bus_ren for 3 cycles, done pulse, rm_mem_load=bus value 0xDEADBEEF.
//  RM write 0x104 data 0x12345678 -> bus_wen, bus_wdata=0x12345678, byte_en=4'hF, done pulse, no fault.
//  RM read addr 0x102 -> no bus activity, done+fault pulse next cycle, rm_mem_busy drops.
//  Core and RM request same cycle -> core served first; RM issued after, rm_mem_busy high throughout.
//  rm_flush during RM_XFER (bus 4 wait) -> transfer finishes, no done pulse, FSM IDLE.
//  nRST asserted in RM_XFER -> outputs reset same cycle; fresh RM read after release completes.

Source files
------------

// File: rtl/rmgmt_mem_pkg.sv
// Shared types and constants for the RISC-MGMT memory servicer.
package rmgmt_mem_pkg;

    // Machine word used on the data bus.
    typedef logic [31:0] word_t;

    // Servicer arbitration / transfer states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_CORE_XFER = 2'b01,
        ST_RM_XFER   = 2'b10,
        ST_RM_DONE   = 2'b11
    } rmgmt_mem_state_t;

    // Extension accesses are always full-word.
    localparam logic [3:0] RM_BYTE_EN = 4'hF;

    // An extension request is refused when it is not word aligned or asks
    // for a read and a write at the same time.
    function automatic logic rm_req_illegal(
        input logic [1:0] addr_lsb,
        input logic       ren,
        input logic       wen
    );
        return (addr_lsb != 2'b00) || (ren && wen);
    endfunction

endpackage

// File: rtl/rmgmt_mem_servicer.sv
// Pipeline-side responder for RISC-MGMT memory requests. Shares the single
// data bus between the execute-stage data port and extension loads/stores.
// The core always wins a tie in IDLE; an extension transfer, once issued, is
// never preempted and always runs to bus completion.
module rmgmt_mem_servicer
    import rmgmt_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    // RISC-MGMT side
    input  logic              rm_req_mem,
    input  logic              rm_mem_ren,
    input  logic              rm_mem_wen,
    input  logic [ADDR_W-1:0] rm_mem_addr,
    input  logic [DATA_W-1:0] rm_mem_store,
    input  logic              rm_flush,
    output logic [DATA_W-1:0] rm_mem_load,
    output logic              rm_mem_busy,
    output logic              rm_mem_done,
    output logic              rm_mem_fault,
    // execute-stage data port
    input  logic              core_ren,
    input  logic              core_wen,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic [3:0]        core_byte_en,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_busy,
    // data bus
    output logic              bus_ren,
    output logic              bus_wen,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_byte_en,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_busy
);

    rmgmt_mem_state_t  state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [DATA_W-1:0] load_q,  load_d;
    logic              ren_q,   ren_d;
    logic              wen_q,   wen_d;
    logic              fault_q, fault_d;
    logic              flush_q, flush_d;

    logic              core_req_s;
    logic              rm_req_s;
    logic              rm_illegal_s;

    assign core_req_s   = core_ren | core_wen;
    assign rm_req_s     = rm_req_mem & (rm_mem_ren | rm_mem_wen) & ~rm_flush;
    assign rm_illegal_s = rm_req_illegal(rm_mem_addr[1:0], rm_mem_ren, rm_mem_wen);

    // State and latched-request registers; reset drops any transfer at once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            store_q <= '0;
            load_q  <= '0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            fault_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            load_q  <= load_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            fault_q <= fault_d;
            flush_q <= flush_d;
        end
    end

    // Next-state: arbitration in IDLE, completion tracking, flush latching.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        store_d = store_q;
        load_d  = load_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        fault_d = fault_q;
        flush_d = flush_q;
        case (state_q)
            ST_IDLE: begin
                flush_d = 1'b0;
                if (core_req_s) begin
                    state_d = ST_CORE_XFER;
                end else if (rm_req_s) begin
                    if (rm_illegal_s) begin
                        // Refused without touching the bus; report on the next cycle.
                        state_d = ST_RM_DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_RM_XFER;
                        fault_d = 1'b0;
                        addr_d  = rm_mem_addr;
                        store_d = rm_mem_store;
                        ren_d   = rm_mem_ren;
                        wen_d   = rm_mem_wen;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CORE_XFER: begin
                if (!bus_busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CORE_XFER;
                end
            end
            ST_RM_XFER: begin
                if (bus_busy) begin
                    state_d = ST_RM_XFER;
                    // Remember a flush even if it is withdrawn before completion.
                    flush_d = flush_q | rm_flush;
                end else if (flush_q || rm_flush) begin
                    // Bus transfer finished but its result is discarded.
                    state_d = ST_IDLE;
                    flush_d = 1'b0;
                end else begin
                    state_d = ST_RM_DONE;
                    if (ren_q) begin
                        load_d = bus_rdata;
                    end else begin
                        load_d = load_q;
                    end
                end
            end
            ST_RM_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output muxing: bus owner selection, busy/done/fault signalling.
    always_comb begin
        bus_ren      = 1'b0;
        bus_wen      = 1'b0;
        bus_addr     = '0;
        bus_wdata    = '0;
        bus_byte_en  = 4'h0;
        core_rdata   = '0;
        core_busy    = core_req_s;
        rm_mem_busy  = rm_req_mem & (state_q != ST_RM_DONE);
        rm_mem_done  = (state_q == ST_RM_DONE);
        rm_mem_fault = (state_q == ST_RM_DONE) & fault_q;
        rm_mem_load  = load_q;
        case (state_q)
            ST_CORE_XFER: begin
                bus_ren     = core_ren;
                bus_wen     = core_wen;
                bus_addr    = core_addr;
                bus_wdata   = core_wdata;
                bus_byte_en = core_byte_en;
                core_busy   = bus_busy;
                core_rdata  = bus_rdata;
            end
            ST_RM_XFER: begin
                // Driven from latched copies so RM input changes cannot disturb the bus.
                bus_ren     = ren_q;
                bus_wen     = wen_q;
                bus_addr    = addr_q;
                bus_wdata   = store_q;
                bus_byte_en = RM_BYTE_EN;
            end
            ST_IDLE, ST_RM_DONE: begin
                bus_ren = 1'b0;
            end
            default: begin
                bus_ren = 1'b0;
            end
        endcase
    end

endmodule
